// File: rtl/comp_pkg.sv
// Shared types and defaults for the comp_core magnitude comparator.
// Result encoding used between the compare chain and the flag registers.
package comp_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        RES_NONE = 2'd0,
        RES_L    = 2'd1,
        RES_E    = 2'd2,
        RES_S    = 2'd3
    } cmp_res_t;

    // gt and lt are mutually exclusive at the end of the chain; neither means equal
    function automatic cmp_res_t encode_res(input logic gt, input logic lt);
        cmp_res_t res;
        if (gt) begin
            res = RES_L;
        end else if (lt) begin
            res = RES_S;
        end else begin
            res = RES_E;
        end
        return res;
    endfunction

endpackage

// File: rtl/comp_slice.sv
// One-bit cascade cell of the comparator chain. A decision made by a more
// significant cell (gt_in/lt_in) is passed through unchanged.
module comp_slice
    import comp_pkg::*;
(
    input  logic a_bit,
    input  logic b_bit,
    input  logic gt_in,
    input  logic lt_in,
    output logic gt_out,
    output logic lt_out
);

    // resolve at this bit only while no higher bit has decided
    always_comb begin
        gt_out = gt_in | (~lt_in & a_bit & ~b_bit);
        lt_out = lt_in | (~gt_in & ~a_bit & b_bit);
    end

endmodule

// File: rtl/comp_core.sv
// Registered magnitude comparator producing one-hot L/E/S flags one cycle after in_valid.
// Optional saturating event counters are enabled by the macro COMP_EVENT_CNT_EN.
module comp_core
    import comp_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int SIGNED_CMP = 0,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             L,
    output logic             E,
    output logic             S,
    output logic             out_valid,
    output logic [CNT_W-1:0] cnt_l,
    output logic [CNT_W-1:0] cnt_e,
    output logic [CNT_W-1:0] cnt_s
);

    logic [WIDTH:0] gt_s;
    logic [WIDTH:0] lt_s;
    cmp_res_t       res_s;
    logic           l_nxt_s;
    logic           e_nxt_s;
    logic           s_nxt_s;
    logic           l_r;
    logic           e_r;
    logic           s_r;
    logic           out_valid_r;

    assign gt_s[WIDTH] = 1'b0;
    assign lt_s[WIDTH] = 1'b0;

    // Chain runs MSB to LSB; swapping the sign bits makes a negative value lose.
    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        localparam bit SWAP = (SIGNED_CMP != 0) && (i == WIDTH - 1);
        logic a_bit_s;
        logic b_bit_s;

        assign a_bit_s = SWAP ? b[i] : a[i];
        assign b_bit_s = SWAP ? a[i] : b[i];

        comp_slice u_slice (
            .a_bit  (a_bit_s),
            .b_bit  (b_bit_s),
            .gt_in  (gt_s[i+1]),
            .lt_in  (lt_s[i+1]),
            .gt_out (gt_s[i]),
            .lt_out (lt_s[i])
        );
    end

    assign res_s = encode_res(gt_s[0], lt_s[0]);

    // decode chain result into the one-hot flag values to be registered
    always_comb begin
        l_nxt_s = 1'b0;
        e_nxt_s = 1'b0;
        s_nxt_s = 1'b0;
        case (res_s)
            RES_L:   l_nxt_s = 1'b1;
            RES_E:   e_nxt_s = 1'b1;
            RES_S:   s_nxt_s = 1'b1;
            default: begin
                l_nxt_s = 1'b0;
                e_nxt_s = 1'b0;
                s_nxt_s = 1'b0;
            end
        endcase
    end

    // flag and valid registers; flags hold when no new pair is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            l_r         <= 1'b0;
            e_r         <= 1'b0;
            s_r         <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (in_valid) begin
            l_r         <= l_nxt_s;
            e_r         <= e_nxt_s;
            s_r         <= s_nxt_s;
            out_valid_r <= 1'b1;
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign L         = l_r;
    assign E         = e_r;
    assign S         = s_r;
    assign out_valid = out_valid_r;

`ifdef COMP_EVENT_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_l_r;
    logic [CNT_W-1:0] cnt_e_r;
    logic [CNT_W-1:0] cnt_s_r;

    // saturating per-result event counters, updated alongside the flags
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_l_r <= {CNT_W{1'b0}};
            cnt_e_r <= {CNT_W{1'b0}};
            cnt_s_r <= {CNT_W{1'b0}};
        end else if (in_valid) begin
            if (l_nxt_s && (cnt_l_r != CNT_MAX)) begin
                cnt_l_r <= cnt_l_r + CNT_ONE;
            end else begin
                cnt_l_r <= cnt_l_r;
            end
            if (e_nxt_s && (cnt_e_r != CNT_MAX)) begin
                cnt_e_r <= cnt_e_r + CNT_ONE;
            end else begin
                cnt_e_r <= cnt_e_r;
            end
            if (s_nxt_s && (cnt_s_r != CNT_MAX)) begin
                cnt_s_r <= cnt_s_r + CNT_ONE;
            end else begin
                cnt_s_r <= cnt_s_r;
            end
        end else begin
            cnt_l_r <= cnt_l_r;
            cnt_e_r <= cnt_e_r;
            cnt_s_r <= cnt_s_r;
        end
    end

    assign cnt_l = cnt_l_r;
    assign cnt_e = cnt_e_r;
    assign cnt_s = cnt_s_r;
`else
    assign cnt_l = {CNT_W{1'b0}};
    assign cnt_e = {CNT_W{1'b0}};
    assign cnt_s = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_comp_core.sv
// Self-checking bench for comp_core: unsigned, signed, 1-bit signed and small-counter instances
// share one stimulus stream; expectations come from an integer reference model via a scoreboard.
module tb_comp_core;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;

    logic        l_u, e_u, s_u, v_u;
    logic [15:0] cl_u, ce_u, cs_u;
    logic        l_s, e_s, s_s, v_s;
    logic [15:0] cl_s, ce_s, cs_s;
    logic        l_1, e_1, s_1, v_1;
    logic [15:0] cl_1, ce_1, cs_1;
    logic        l_c, e_c, s_c, v_c;
    logic [1:0]  cl_c, ce_c, cs_c;

    typedef struct {
        string      tag;
        logic [2:0] fu;
        logic [2:0] fs;
        logic [2:0] f1;
        logic       vld;
        logic [1:0] cl;
        logic [1:0] ce;
        logic [1:0] cs;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;

    logic [2:0] hu, hs, h1;
    logic       hv;
    logic [1:0] mcl, mce, mcs;

    comp_core #(.WIDTH(4), .SIGNED_CMP(0), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
        .L(l_u), .E(e_u), .S(s_u), .out_valid(v_u),
        .cnt_l(cl_u), .cnt_e(ce_u), .cnt_s(cs_u)
    );

    comp_core #(.WIDTH(4), .SIGNED_CMP(1), .CNT_W(16)) u_sgn (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
        .L(l_s), .E(e_s), .S(s_s), .out_valid(v_s),
        .cnt_l(cl_s), .cnt_e(ce_s), .cnt_s(cs_s)
    );

    comp_core #(.WIDTH(1), .SIGNED_CMP(1), .CNT_W(16)) u_w1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a[0:0]), .b(b[0:0]),
        .L(l_1), .E(e_1), .S(s_1), .out_valid(v_1),
        .cnt_l(cl_1), .cnt_e(ce_1), .cnt_s(cs_1)
    );

    comp_core #(.WIDTH(4), .SIGNED_CMP(0), .CNT_W(2)) u_cnt (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
        .L(l_c), .E(e_c), .S(s_c), .out_valid(v_c),
        .cnt_l(cl_c), .cnt_e(ce_c), .cnt_s(cs_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference compare returning {L,E,S}; operands interpreted as w-bit values
    function automatic logic [2:0] cmp_model(input int av, input int bv, input int w, input bit sgn);
        int x;
        int y;
        x = av;
        y = bv;
        if (sgn) begin
            if (x >= (1 << (w - 1))) x = x - (1 << w);
            if (y >= (1 << (w - 1))) y = y - (1 << w);
        end
        if (x > y) return 3'b100;
        if (x == y) return 3'b010;
        return 3'b001;
    endfunction

    function automatic logic [1:0] sat_inc(input logic [1:0] c, input logic hit);
        if (hit && (c != 2'd3)) return c + 2'd1;
        return c;
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // drive one cycle of stimulus, push the expected outcome, then compare after the edge
    task automatic step(input logic r, input logic v, input logic [3:0] av, input logic [3:0] bv,
                        input string tag);
        exp_t x;
        exp_t y;
        @(negedge clk);
        rst      = r;
        in_valid = v;
        a        = av;
        b        = bv;
        if (r) begin
            hu = 3'b000; hs = 3'b000; h1 = 3'b000; hv = 1'b0;
            mcl = 2'd0; mce = 2'd0; mcs = 2'd0;
        end else if (v) begin
            hu = cmp_model(int'(av), int'(bv), 4, 1'b0);
            hs = cmp_model(int'(av), int'(bv), 4, 1'b1);
            h1 = cmp_model(int'(av[0]), int'(bv[0]), 1, 1'b1);
            hv = 1'b1;
`ifdef COMP_EVENT_CNT_EN
            mcl = sat_inc(mcl, hu[2]);
            mce = sat_inc(mce, hu[1]);
            mcs = sat_inc(mcs, hu[0]);
`endif
        end else begin
            hv = 1'b0;
        end
        x.tag = tag; x.fu = hu; x.fs = hs; x.f1 = h1; x.vld = hv;
        x.cl = mcl; x.ce = mce; x.cs = mcs;
        sb.push_back(x);
        @(posedge clk);
        #1;
        y = sb.pop_front();
        check({y.tag, "/unsigned"}, {v_u, l_u, e_u, s_u}, {y.vld, y.fu});
        check({y.tag, "/signed"},   {v_s, l_s, e_s, s_s}, {y.vld, y.fs});
        check({y.tag, "/w1"},       {v_1, l_1, e_1, s_1}, {y.vld, y.f1});
        check({y.tag, "/cntflags"}, {v_c, l_c, e_c, s_c}, {y.vld, y.fu});
        check({y.tag, "/cnt_l"}, {2'b00, cl_c}, {2'b00, y.cl});
        check({y.tag, "/cnt_e"}, {2'b00, ce_c}, {2'b00, y.ce});
        check({y.tag, "/cnt_s"}, {2'b00, cs_c}, {2'b00, y.cs});
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = 4'd0; b = 4'd0;
        hu = 3'b000; hs = 3'b000; h1 = 3'b000; hv = 1'b0;
        mcl = 2'd0; mce = 2'd0; mcs = 2'd0;

        step(1'b1, 1'b0, 4'd0, 4'd0, "reset0");
        step(1'b1, 1'b0, 4'd0, 4'd0, "reset1");
        step(1'b0, 1'b0, 4'd0, 4'd0, "idle_after_reset");
        check("default_cnt_l_zero", cl_u[3:0], 4'd0);

        step(1'b0, 1'b1, 4'd5,  4'd5,  "eq_5_5");
        step(1'b0, 1'b1, 4'd9,  4'd3,  "gt_9_3");
        step(1'b0, 1'b0, 4'd0,  4'd15, "hold");
        step(1'b0, 1'b1, 4'd2,  4'd7,  "lt_2_7");
        step(1'b0, 1'b1, 4'd0,  4'd1,  "lt_0_1");
        step(1'b0, 1'b1, 4'd14, 4'd7,  "cmp_14_7");
        step(1'b0, 1'b1, 4'd0,  4'd0,  "zero_zero");
        step(1'b0, 1'b1, 4'd15, 4'd0,  "ones_zero");
        step(1'b0, 1'b1, 4'd7,  4'd8,  "cmp_7_8");
        step(1'b0, 1'b1, 4'd8,  4'd8,  "eq_8_8");
        step(1'b0, 1'b1, 4'd1,  4'd0,  "w1_m1_vs_0");

        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), "random");
        end

        step(1'b0, 1'b1, 4'd9, 4'd3, "pre_reset_gt");
        step(1'b1, 1'b1, 4'd9, 4'd3, "reset_beats_valid");

        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 4'd6, 4'd6, "sat_eq");
        end
        step(1'b0, 1'b1, 4'd3, 4'd12, "after_sat_lt");
        step(1'b1, 1'b0, 4'd0, 4'd0, "reset_clears_cnt");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
